dpr_fifo_ctrl: RTL and testbench
================================

Name: dpr_fifo_ctrl

Overview:
Synchronous FIFO controller that sequences one dpr_sync dual-port RAM instance as a circular buffer. It owns the write and read pointers, the occupancy count and the full/empty flags. It drives every RAM control and address port and returns RAM read data to the consumer with a valid strobe. It sits between a single producer and a single consumer and the dpr_sync instance.

Parameters:
MEM_WIDTH, 16, data width; must match the dpr_sync instance.
MEM_DEPTH, 1024, number of RAM entries; need not be a power of two.
ADDR_SIZE, 10, RAM address width; must satisfy 2^ADDR_SIZE >= MEM_DEPTH.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  asynchronous, active-low reset.
push  in  1  producer write request.
push_data  in  MEM_WIDTH  data to enqueue.
pop  in  1  consumer read request.
flush  in  1  synchronous clear of FIFO contents.
pop_data  out  MEM_WIDTH  dequeued data; passthrough of ram_dout.
pop_valid  out  1  pop_data valid this cycle.
full  out  1  count == MEM_DEPTH, or init sweep active.
empty  out  1  count == 0.
count  out  ADDR_SIZE+1  current occupancy.
overflow  out  1  one-cycle pulse: push was rejected.
underflow  out  1  one-cycle pulse: pop was rejected.
busy  out  1  init sweep active.
ram_din  out  MEM_WIDTH  to dpr_sync din.
ram_add_wr  out  ADDR_SIZE  to dpr_sync add_wr.
ram_add_rd  out  ADDR_SIZE  to dpr_sync add_rd.
ram_wr_en  out  1  to dpr_sync wr_en.
ram_rd_en  out  1  to dpr_sync rd_en.
ram_blk_select  out  1  to dpr_sync blk_select.
ram_dout  in  MEM_WIDTH  from dpr_sync dout.

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, pop_valid=0, overflow=0, underflow=0. Outputs at reset: empty=1, full=0 (full=1 and busy=1 if the init sweep is compiled in).
- Reset asserted mid-operation: state is discarded; there is no recovery of in-flight data.
- RAM ports are combinational from the accept logic:
  - ram_wr_en = push_acc; ram_rd_en = pop_acc.
  - ram_blk_select = ram_wr_en | ram_rd_en.
  - ram_add_wr = wr_ptr; ram_add_rd = rd_ptr; ram_din = push_data.
- pop_acc = pop & ~empty & ~flush & ~busy.
- push_acc = push & ~flush & ~busy & (~full_cnt | pop_acc).
  - full_cnt is count == MEM_DEPTH.
  - When the FIFO is full, a push is accepted only in a cycle where a pop is also accepted.
- Empty FIFO: a pop is rejected even if a push arrives in the same cycle. There is no write-to-read bypass.
- Pointer update: on acceptance the pointer increments; it wraps from MEM_DEPTH-1 to 0.
- Count update:
  - +1 on push_acc only.
  - -1 on pop_acc only.
  - Unchanged when both are accepted.
- Read latency: one cycle.
  - pop_valid is a register set to pop_acc.
  - pop_data = ram_dout, which dpr_sync registers at the same edge.
- Overflow: overflow is registered from (push & ~push_acc & ~flush), so it pulses one cycle after a rejected push.
- Underflow: underflow is registered from (pop & ~pop_acc & ~flush), so it pulses one cycle after a rejected pop.
- Flush: sets pointers and count to 0 at the next edge and overrides same-cycle push/pop.
  - pop_valid for a pop accepted in the preceding cycle is still emitted.
- RAM contents are never cleared by flush.

Optional Feature:
Macro DPR_FIFO_INIT_CLEAR_EN enables a post-reset clear of the RAM.
- With the macro:
  - Two-state FSM, INIT then RUN. Reset enters INIT with sweep address 0 and busy=1.
  - INIT, each cycle: ram_wr_en=1, ram_blk_select=1, ram_add_wr=sweep address, ram_din=0.
  - The sweep address increments each cycle. After writing MEM_DEPTH-1, the FSM moves to RUN, so INIT lasts exactly MEM_DEPTH cycles.
  - In INIT: full=1, empty=1; push/pop are rejected and raise overflow/underflow; flush is ignored.
  - RUN is absorbing until the next reset.
- Without the macro: busy is tied to 0, there is no FSM, and the block starts in normal operation straight from reset.

Decomposition:
- A shared package dpr_fifo_pkg holds:
  - MEM_WIDTH, MEM_DEPTH and ADDR_SIZE defaults.
  - The count width, ADDR_SIZE+1.
  - The init FSM state encoding: INIT=1'b0, RUN=1'b1.
- One sub-module, dpr_fifo_ptr: a parameterised wrapping pointer with inc and clr inputs, instanced for both the write and read pointers.
- Full/empty/count logic stays in the top module.

Test Plan:
- Reset then 5 pushes (data 0x0001..0x0005), then 5 pops: pop_valid appears one cycle after each pop with data 0x0001..0x0005 in order; count goes 5 then 0; empty=1.
- Fill with 1024 pushes: full=1, count=1024. A 1025th push gives an overflow pulse and count stays 1024. A simultaneous push+pop while full is accepted and count stays 1024.
- Pop while empty with a push in the same cycle: underflow pulses; count=1 afterwards; the next pop returns the pushed data.
- Wrap: push/pop 1500 items at steady state with count held at 3: ram_add_wr wraps 1023 to 0, and data integrity holds across the wrap.
- Flush with count=7 and push+pop asserted: next cycle count=0, empty=1, no RAM write. pop_valid for the previous cycle's pop still fires.
- DPR_FIFO_INIT_CLEAR_EN defined: busy stays high for 1024 cycles after rst rises. A push during that window pulses overflow. All RAM words read 0x0000 afterwards.

Source files
------------

// File: rtl/dpr_fifo_pkg.sv
// Shared sizing defaults and init-sweep state encoding for the dpr_sync FIFO controller.
package dpr_fifo_pkg;

   localparam int MEM_WIDTH_DEF = 16;
   localparam int MEM_DEPTH_DEF = 1024;
   localparam int ADDR_SIZE_DEF = 10;
   localparam int CNT_W_DEF     = ADDR_SIZE_DEF + 1;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } init_state_e;

   // Occupancy must reach MEM_DEPTH itself, hence one bit beyond the address width.
   function automatic int cnt_width(input int addr_size);
      return addr_size + 1;
   endfunction

endpackage

// File: rtl/dpr_fifo_ptr.sv
// Wrapping circular-buffer pointer; wraps DEPTH-1 -> 0, so DEPTH need not be a power of two.
module dpr_fifo_ptr #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          clr,
   output logic [AW-1:0] ptr
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
      end
   end

endmodule

// File: rtl/dpr_fifo_ctrl.sv
// FIFO controller sequencing one dpr_sync RAM as a circular buffer.
// Optional post-reset RAM clear sweep: define DPR_FIFO_INIT_CLEAR_EN.
module dpr_fifo_ctrl
   import dpr_fifo_pkg::*;
#(
   parameter int MEM_WIDTH = MEM_WIDTH_DEF,
   parameter int MEM_DEPTH = MEM_DEPTH_DEF,
   parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [MEM_WIDTH-1:0] push_data,
   input  logic                 pop,
   input  logic                 flush,
   output logic [MEM_WIDTH-1:0] pop_data,
   output logic                 pop_valid,
   output logic                 full,
   output logic                 empty,
   output logic [ADDR_SIZE:0]   count,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 busy,
   output logic [MEM_WIDTH-1:0] ram_din,
   output logic [ADDR_SIZE-1:0] ram_add_wr,
   output logic [ADDR_SIZE-1:0] ram_add_rd,
   output logic                 ram_wr_en,
   output logic                 ram_rd_en,
   output logic                 ram_blk_select,
   input  logic [MEM_WIDTH-1:0] ram_dout
);

   localparam int                 CNT_W     = cnt_width(ADDR_SIZE);
   localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(MEM_DEPTH);

   logic                 full_cnt;
   logic                 push_acc;
   logic                 pop_acc;
   logic                 flush_eff;
   logic [ADDR_SIZE-1:0] wr_ptr;
   logic [ADDR_SIZE-1:0] rd_ptr;

   // Handshake: push/pop are requests with no ready return; a request is taken
   // exactly when push_acc/pop_acc is high that cycle, otherwise it is dropped
   // and flagged one cycle later on overflow/underflow. pop_valid qualifies
   // pop_data one cycle after an accepted pop.
   assign full_cnt  = (count == DEPTH_CNT);
   assign empty     = (count == '0);
   assign full      = full_cnt | busy;
   assign flush_eff = flush & ~busy;
   assign pop_acc   = pop & ~empty & ~flush & ~busy;
   assign push_acc  = push & ~flush & ~busy & (~full_cnt | pop_acc);

   dpr_fifo_ptr #(.DEPTH(MEM_DEPTH), .AW(ADDR_SIZE)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .inc (push_acc),
      .clr (flush_eff),
      .ptr (wr_ptr)
   );

   dpr_fifo_ptr #(.DEPTH(MEM_DEPTH), .AW(ADDR_SIZE)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .inc (pop_acc),
      .clr (flush_eff),
      .ptr (rd_ptr)
   );

`ifdef DPR_FIFO_INIT_CLEAR_EN
   init_state_e          state;
   logic [ADDR_SIZE-1:0] sweep_addr;

   // INIT writes zero to every entry once, then RUN holds until the next reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= INIT;
         sweep_addr <= '0;
      end else if (state == INIT) begin
         sweep_addr <= sweep_addr + 1'b1;
         if (sweep_addr == ADDR_SIZE'(MEM_DEPTH - 1)) begin
            state <= RUN;
         end
      end
   end

   assign busy       = (state == INIT);
   assign ram_wr_en  = busy | push_acc;
   assign ram_add_wr = busy ? sweep_addr : wr_ptr;
   assign ram_din    = busy ? '0 : push_data;
`else
   assign busy       = 1'b0;
   assign ram_wr_en  = push_acc;
   assign ram_add_wr = wr_ptr;
   assign ram_din    = push_data;
`endif

   assign ram_rd_en      = pop_acc;
   assign ram_blk_select = ram_wr_en | ram_rd_en;
   assign ram_add_rd     = rd_ptr;
   assign pop_data       = ram_dout;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count     <= '0;
         pop_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         pop_valid <= pop_acc;
         overflow  <= push & ~push_acc & ~flush_eff;
         underflow <= pop & ~pop_acc & ~flush_eff;
         if (flush_eff) begin
            count <= '0;
         end else if (push_acc && !pop_acc) begin
            count <= count + 1'b1;
         end else if (pop_acc && !push_acc) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dpr_fifo_ctrl.sv
// Bench for dpr_fifo_ctrl with a behavioural read-first dpr_sync model; covers DPR_FIFO_INIT_CLEAR_EN when defined.
module tb_dpr_fifo_ctrl;

   localparam int W = 16;
   localparam int D = 1024;
   localparam int A = 10;
`ifdef DPR_FIFO_INIT_CLEAR_EN
   localparam bit INIT_EN = 1'b1;
`else
   localparam bit INIT_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         push = 1'b0;
   logic [W-1:0] push_data = '0;
   logic         pop = 1'b0;
   logic         flush = 1'b0;
   logic [W-1:0] pop_data;
   logic         pop_valid;
   logic         full;
   logic         empty;
   logic [A:0]   count;
   logic         overflow;
   logic         underflow;
   logic         busy;
   logic [W-1:0] ram_din;
   logic [A-1:0] ram_add_wr;
   logic [A-1:0] ram_add_rd;
   logic         ram_wr_en;
   logic         ram_rd_en;
   logic         ram_blk_select;
   logic [W-1:0] ram_dout = '0;

   // clock / reset block
   always #5 clk = ~clk;

   dpr_fifo_ctrl #(.MEM_WIDTH(W), .MEM_DEPTH(D), .ADDR_SIZE(A)) dut (
      .clk            (clk),
      .rst            (rst),
      .push           (push),
      .push_data      (push_data),
      .pop            (pop),
      .flush          (flush),
      .pop_data       (pop_data),
      .pop_valid      (pop_valid),
      .full           (full),
      .empty          (empty),
      .count          (count),
      .overflow       (overflow),
      .underflow      (underflow),
      .busy           (busy),
      .ram_din        (ram_din),
      .ram_add_wr     (ram_add_wr),
      .ram_add_rd     (ram_add_rd),
      .ram_wr_en      (ram_wr_en),
      .ram_rd_en      (ram_rd_en),
      .ram_blk_select (ram_blk_select),
      .ram_dout       (ram_dout)
   );

   // dpr_sync model: registered read, old data on same-address read/write
   logic [W-1:0] mem [D];
   logic         preload = 1'b1;
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < D; i++) mem[i] <= 16'hA5A5;
      end else if (ram_blk_select) begin
         if (ram_wr_en) mem[ram_add_wr] <= ram_din;
         if (ram_rd_en) ram_dout <= mem[ram_add_rd];
      end
   end

   // scoreboard and reference model state
   logic [W-1:0] exp_q[$];
   logic [W-1:0] fifo_q[$];
   int  m_count = 0;
   int  m_wr = 0;
   int  m_rd = 0;
   logic last_valid = 1'b0;
   logic saw_top = 1'b0;
   logic wrap_ok = 1'b0;
   int  n_checks = 0;
   int  n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: apply at posedge+1, check RAM ports at negedge, check registered outputs at next posedge+1.
   task automatic cycle(input logic p, input logic [W-1:0] d, input logic q, input logic f);
      logic mp, mq, eo, eu;
      logic [W-1:0] e;
      push = p; push_data = d; pop = q; flush = f;
      mq = q && (m_count != 0) && !f;
      mp = p && !f && ((m_count != D) || mq);
      @(negedge clk);
      chk("pop_valid_hold", 32'(pop_valid), 32'(last_valid));
      chk("ram_wr_en", 32'(ram_wr_en), 32'(mp));
      chk("ram_rd_en", 32'(ram_rd_en), 32'(mq));
      chk("ram_blk_select", 32'(ram_blk_select), 32'(mp | mq));
      if (mp) begin
         chk("ram_add_wr", 32'(ram_add_wr), 32'(m_wr));
         chk("ram_din", 32'(ram_din), 32'(d));
      end
      if (mq) chk("ram_add_rd", 32'(ram_add_rd), 32'(m_rd));
      if (ram_wr_en) begin
         if (ram_add_wr == A'(D - 1)) saw_top = 1'b1;
         else if (ram_add_wr == '0 && saw_top) wrap_ok = 1'b1;
      end
      if (mq) begin
         exp_q.push_back(fifo_q.pop_front());
         m_rd = (m_rd == D - 1) ? 0 : m_rd + 1;
      end
      if (mp) begin
         fifo_q.push_back(d);
         m_wr = (m_wr == D - 1) ? 0 : m_wr + 1;
      end
      if (f) begin
         fifo_q.delete();
         m_wr = 0; m_rd = 0; m_count = 0;
      end else begin
         m_count = m_count + int'(mp) - int'(mq);
      end
      eo = p && !mp && !f;
      eu = q && !mq && !f;
      last_valid = mq;
      @(posedge clk); #1;
      chk("pop_valid", 32'(pop_valid), 32'(mq));
      if (mq) begin
         e = exp_q.pop_front();
         chk("pop_data", 32'(pop_data), 32'(e));
      end
      chk("overflow", 32'(overflow), 32'(eo));
      chk("underflow", 32'(underflow), 32'(eu));
      chk("count", 32'(count), 32'(m_count));
      chk("empty", 32'(empty), 32'(m_count == 0));
      chk("full", 32'(full), 32'(m_count == D));
      chk("busy", 32'(busy), 32'd0);
      push = 1'b0; pop = 1'b0; flush = 1'b0;
   endtask

   typedef struct {
      logic         p;
      logic [W-1:0] d;
      logic         q;
      logic         f;
      int           cnt;
      logic         emp;
      logic         ovf;
      logic         unf;
   } vec_t;

   vec_t tbl[14];

   initial begin
      int n;
      int nz;
      // push 1..5, pop 5, then pop-while-empty with a same-cycle push
      tbl[0]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 16'h0002, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 16'h00AA, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};

      // reset
      @(posedge clk); #1;
      preload = 1'b0;
      @(posedge clk); #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'(INIT_EN));
      chk("rst_busy", 32'(busy), 32'(INIT_EN));
      chk("rst_pop_valid", 32'(pop_valid), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      if (INIT_EN) begin
         n = 0;
         for (int k = 0; k < 2000; k++) begin
            push = (k == 3);
            pop  = (k == 5);
            @(posedge clk); #1;
            n++;
            if (k == 0) begin
               chk("init_full", 32'(full), 32'd1);
               chk("init_empty", 32'(empty), 32'd1);
            end
            if (k == 3) chk("init_overflow", 32'(overflow), 32'd1);
            if (k == 5) chk("init_underflow", 32'(underflow), 32'd1);
            if (!busy) break;
         end
         push = 1'b0; pop = 1'b0;
         chk("init_cycles", 32'(n), 32'(D));
         nz = 0;
         for (int i = 0; i < D; i++) if (mem[i] != '0) nz++;
         chk("init_ram_zero", 32'(nz), 32'd0);
      end else begin
         @(posedge clk); #1;
      end

      // table-driven basic sequence
      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].p, tbl[i].d, tbl[i].q, tbl[i].f);
         chk("tbl_count", 32'(count), 32'(tbl[i].cnt));
         chk("tbl_empty", 32'(empty), 32'(tbl[i].emp));
         chk("tbl_overflow", 32'(overflow), 32'(tbl[i].ovf));
         chk("tbl_underflow", 32'(underflow), 32'(tbl[i].unf));
      end

      // fill to full, reject one push, then push+pop while full
      for (int i = 0; i < D; i++) cycle(1'b1, W'($urandom_range(0, 65535)), 1'b0, 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'(D));
      cycle(1'b1, 16'hBEEF, 1'b0, 1'b0);
      chk("full_overflow", 32'(overflow), 32'd1);
      chk("full_count_hold", 32'(count), 32'(D));
      cycle(1'b1, 16'h5A5A, 1'b1, 1'b0);
      chk("full_pushpop_count", 32'(count), 32'(D));
      for (int i = 0; i < D; i++) cycle(1'b0, '0, 1'b1, 1'b0);
      chk("drain_empty", 32'(empty), 32'd1);

      // steady-state wrap at occupancy 3
      saw_top = 1'b0; wrap_ok = 1'b0;
      for (int i = 0; i < 3; i++) cycle(1'b1, W'($urandom_range(0, 65535)), 1'b0, 1'b0);
      for (int i = 0; i < 1500; i++) begin
         cycle(1'b1, W'($urandom_range(0, 65535)), 1'b1, 1'b0);
         if (i == 0 || i == 1499) chk("wrap_count", 32'(count), 32'd3);
      end
      chk("wr_wrap", 32'(wrap_ok), 32'd1);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

      // flush at count 7 with push+pop, preceded by an accepted pop
      for (int i = 0; i < 8; i++) cycle(1'b1, W'(16'h0100 + i), 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("pre_flush_count", 32'(count), 32'd7);
      cycle(1'b1, 16'hCAFE, 1'b1, 1'b1);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_empty", 32'(empty), 32'd1);
      cycle(1'b1, 16'h1234, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
